// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// fills the IF/ID register; handles branch redirects and decode stalls.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [63:0]  branch_pc,
  input  logic [63:0]  branch_imm,
  output logic         ifid_valid,
  output logic [63:0]  ifid_pc,
  output logic [31:0]  ifid_instr,
  output logic         fetch_misaligned
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        stale_q, stale_d;
  logic [31:0] hold_q, hold_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        mis_q, mis_d;

  logic [63:0] target_raw, target, pc_inc;
  logic        fresh_resp, load;
  logic [31:0] load_instr;
  logic        pending;

  assign imem.imem_req_valid = (state_q == FETCH) && !branch_taken;
  assign imem.imem_req_addr  = pc_q;

  assign ifid_valid       = ifid_valid_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_instr       = ifid_instr_q;
  assign fetch_misaligned = mis_q;

  always_comb begin
    target_raw = branch_pc + (branch_imm << 1);
    target     = {target_raw[63:2], 2'b00};
    pc_inc     = pc_q + 64'd4;
    mis_d      = branch_taken && (target_raw[1:0] != 2'b00);

    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    hold_d     = hold_q;
    load       = 1'b0;
    load_instr = imem.imem_resp_data;

    // A response owed to a pre-reset request is swallowed without touching state.
    fresh_resp = imem.imem_resp_valid && !stale_q;
    stale_d    = stale_q && !imem.imem_resp_valid;
    pending    = (state_q == WAIT) || stale_q ||
                 (imem.imem_req_valid && imem.imem_req_ready);

    case (state_q)
      FETCH: begin
        if (branch_taken)             pc_d = target;
        else if (imem.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (branch_taken) begin
          pc_d = target;
          if (fresh_resp) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (fresh_resp) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else if (!stall) begin
            load    = 1'b1;
            pc_d    = pc_inc;
            state_d = FETCH;
          end else begin
            hold_d  = imem.imem_resp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_inc;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (branch_taken) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall) begin
      ifid_valid_d = load;
      if (load) begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = load_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      stale_q      <= pending && !imem.imem_resp_valid;
      hold_q       <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      stale_q      <= stale_d;
      hold_q       <= hold_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      mis_q        <= mis_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the immediate generator and decoder. It holds the 64-bit PC, issues one instruction-memory request at a time, and loads the returned 32-bit word plus its PC into the IF/ID register. It also accepts branch redirects, computing the target from the decoded immediate produced downstream.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'h00000013, instruction word placed in IF/ID on reset and on flush (addi x0,x0,0).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  64  fetch byte address (current PC)
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  read data valid (exactly one per accepted request)
imem_resp_data  input  32  instruction word
stall  input  1  hold IF/ID contents (decode not consuming)
branch_taken  input  1  single-cycle redirect request
branch_pc  input  64  PC of the branch instruction
branch_imm  input  64  sign-extended immediate from immediate generator (halfword offset)
ifid_valid  output  1  IF/ID holds a live instruction
ifid_pc  output  64  PC of ifid_instr
ifid_instr  output  32  fetched instruction
fetch_misaligned  output  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
- Reset, sampled on clk: pc = RESET_PC; state = FETCH; ifid_valid = 0; ifid_pc = 0; ifid_instr = NOP_INSTR; fetch_misaligned = 0; kill flag cleared. Reset mid-transaction also drops any outstanding response, so the first response after reset deassertion is discarded if a request was pending.
- Redirect target = branch_pc + (branch_imm << 1), modulo 2^64; bits [1:0] forced to 0 before loading pc. fetch_misaligned pulses in the cycle after the redirect when the unforced target bits [1:0] != 0.
- imem_req_valid = (state == FETCH) && !branch_taken. imem_req_addr = pc.
- FETCH:
  - branch_taken: pc = target; stay in FETCH.
  - Otherwise, when imem_req_ready: go to WAIT.
- WAIT:
  - branch_taken: pc = target; set kill.
  - When imem_resp_valid with kill set: discard the data, clear kill, go to FETCH.
  - When imem_resp_valid with kill clear and stall = 0: load IF/ID (valid = 1, pc, data); pc += 4; go to FETCH.
  - When imem_resp_valid with kill clear and stall = 1: capture the word in a hold buffer; go to HOLD.
  - branch_taken in the same cycle as resp_valid: discard the data; pc = target; go to FETCH.
- HOLD:
  - When stall drops: load IF/ID from the hold buffer; pc += 4; go to FETCH.
  - branch_taken: drop the buffer; pc = target; go to FETCH.
- IF/ID register:
  - Changes only on a load or a flush.
  - stall = 1 freezes all three fields.
  - When stall = 0 and no load occurs, ifid_valid = 0 (bubble). ifid_pc and ifid_instr keep their values.
  - branch_taken flushes regardless of stall: ifid_valid = 0, ifid_instr = NOP_INSTR. The flush beats a simultaneous load.
- Latency: with no stalls, memory ready, and 1-cycle response, IF/ID updates every 2 cycles. Request-to-IF/ID is 1 cycle after resp_valid.
- At most one outstanding request. pc increment wraps at 2^64 (pc = 64'hFFFF_FFFF_FFFF_FFFC becomes 0).

Test Plan:
- Reset with RESET_PC = 64'h1000, ready = 1, 1-cycle response 32'h00A00093 -> imem_req_addr = 0x1000; next IF/ID = {1, 0x1000, 0x00A00093}; next request addr = 0x1004.
- Stall held 3 cycles while resp_valid arrives with 32'h00000513 -> IF/ID unchanged during the stall, state HOLD. The cycle after stall drops, IF/ID = that word and pc advances by 4.
- In WAIT, branch_taken with branch_pc = 0x2000 and branch_imm = 64'hFFFF_FFFF_FFFF_FFF8 -> late response discarded; next request addr = 0x1FF0; IF/ID = {0, -, NOP}.
- branch_taken together with imem_req_ready in FETCH -> imem_req_valid = 0 that cycle; next request addr = new target; no response expected for the old PC.
- branch_pc = 0x100 with branch_imm = 1 (target 0x102) -> pc = 0x100 and fetch_misaligned pulses for exactly 1 cycle.
- Reset asserted in WAIT, response arriving 2 cycles later -> response ignored, first request after reset uses RESET_PC, ifid_valid stays 0.
